mod_n_prog_counter: RTL and testbench

Parametrised modulo counter with a modulus that can be changed at runtime. Supports up or down counting, synchronous load, and three end-of-range modes: wrap, saturate and one-shot. Used as a general timing and sequencing counter; the wrap pulse and tc flag let instances be cascaded. Counts over the range 0..M inclusive, where M is the current modulus register value.

---
 rtl/mod_n_prog_counter.sv | 108 ++++++++++
 tb/tb_mod_n_prog_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_prog_counter.sv
// Modulo-M up/down counter with a runtime-writable modulus, synchronous load and
// wrap / saturate / one-shot end-of-range behaviour. tc and wrap allow cascading.
module mod_n_prog_counter #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_MOD = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] RESET_MOD = WIDTH'(DEFAULT_MOD);

    localparam logic [1:0] MODE_SAT = 2'b01;
    localparam logic [1:0] MODE_ONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             wrap_q, wrap_d;
    state_t           state_q, state_d;

    logic is_one_shot;
    logic is_sat;
    logic start_ok;
    logic step;
    logic at_end;

    always_comb begin
        is_one_shot = (mode == MODE_ONE);
        is_sat      = (mode == MODE_SAT);
        start_ok    = start && is_one_shot && (state_q != ST_RUN);
        step        = en && (!is_one_shot || state_q == ST_RUN);
        // End of range depends on direction: M when counting up, 0 when counting down.
        at_end      = dir ? (count_q == '0) : (count_q == mod_q);
    end

    always_comb begin
        count_d = count_q;
        mod_d   = mod_q;
        state_d = state_q;
        wrap_d  = 1'b0;

        if (mod_wr) begin
            mod_d = mod_val;
            if (count_q > mod_val) begin
                count_d = '0;
            end
        end else if (load) begin
            count_d = (load_val > mod_q) ? mod_q : load_val;
        end else if (start_ok) begin
            count_d = dir ? mod_q : '0;
            state_d = ST_RUN;
        end else if (step) begin
            if (!at_end) begin
                count_d = dir ? (count_q - 1'b1) : (count_q + 1'b1);
            end else if (is_one_shot) begin
                state_d = ST_DONE;
            end else if (!is_sat) begin
                count_d = dir ? mod_q : '0;
                wrap_d  = 1'b1;
            end
        end

        // Leaving one-shot mode always abandons any one-shot in progress.
        if (!is_one_shot) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
            mod_q   <= RESET_MOD;
            wrap_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            count_q <= count_d;
            mod_q   <= mod_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign tc    = (!dir && count_q == mod_q) || (dir && count_q == '0);
    assign wrap  = wrap_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_mod_n_prog_counter.sv
// Bench for mod_n_prog_counter: directed counting loop, a vector table for the
// documented corner cases, then randomized traffic against a reference model.
module tb_mod_n_prog_counter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             resetn;
    logic             en;
    logic             dir;
    logic [1:0]       mode;
    logic             mod_wr;
    logic [WIDTH-1:0] mod_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             busy;
    logic             done;

    mod_n_prog_counter #(.WIDTH(WIDTH), .DEFAULT_MOD(15)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .mod_wr   (mod_wr),
        .mod_val  (mod_val),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic       en;
        logic       dir;
        logic [1:0] mode;
        logic       mw;
        int         mv;
        logic       ld;
        int         lv;
        logic       st;
        int         e_count;
        logic       e_tc;
        logic       e_wrap;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: count, modulus, one-shot phase (0 idle, 1 running, 2 finished).
    int m_cnt, m_mod, m_ph, m_wrap;

    task automatic add(input logic rs, input logic e, input logic d, input logic [1:0] md,
                       input logic mw, input int mv, input logic ld, input int lv,
                       input logic st, input int ec, input logic etc, input logic ew,
                       input logic eb, input logic ed);
        vec_t v;
        v.rstn = rs; v.en = e; v.dir = d; v.mode = md; v.mw = mw; v.mv = mv;
        v.ld = ld; v.lv = lv; v.st = st; v.e_count = ec; v.e_tc = etc;
        v.e_wrap = ew; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic rs, input logic e, input logic d, input logic [1:0] md,
                          input logic mw, input int mv, input logic ld, input int lv,
                          input logic st);
        resetn = rs; en = e; dir = d; mode = md; mod_wr = mw;
        mod_val = WIDTH'(mv); load = ld; load_val = WIDTH'(lv); start = st;
    endtask

    // Advance the model from the spec's rules using the inputs now on the pins.
    task automatic model_step();
        int nw;
        bit one;
        nw  = 0;
        one = (mode == 2'b10);
        if (!resetn) begin
            m_cnt = 0; m_mod = 15; m_ph = 0; m_wrap = 0;
            return;
        end
        if (mod_wr) begin
            if (m_cnt > int'(mod_val)) m_cnt = 0;
            m_mod = int'(mod_val);
        end else if (load) begin
            m_cnt = (int'(load_val) < m_mod) ? int'(load_val) : m_mod;
        end else if (start && one && m_ph != 1) begin
            m_cnt = dir ? m_mod : 0;
            m_ph  = 1;
        end else if (en && (!one || m_ph == 1)) begin
            if (one) begin
                if ((dir == 1'b0 && m_cnt == m_mod) || (dir == 1'b1 && m_cnt == 0)) m_ph = 2;
                else m_cnt = dir ? m_cnt - 1 : m_cnt + 1;
            end else if (mode == 2'b01) begin
                m_cnt = dir ? ((m_cnt > 0) ? m_cnt - 1 : 0)
                            : ((m_cnt < m_mod) ? m_cnt + 1 : m_mod);
            end else begin
                nw    = dir ? (m_cnt == 0) : (m_cnt == m_mod);
                m_cnt = dir ? (m_cnt + m_mod) % (m_mod + 1) : (m_cnt + 1) % (m_mod + 1);
            end
        end
        if (!one) m_ph = 0;
        m_wrap = nw;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
        m_cnt = 0; m_mod = 15; m_ph = 0; m_wrap = 0;

        // Reset state
        tick();
        check("reset count", int'(count), 0);
        check("reset tc", int'(tc), 0);
        check("reset wrap", int'(wrap), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        // Free-running up count in wrap mode with M=15, stops at count 9
        for (k = 1; k <= 25; k++) begin
            set_in(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
            tick();
            check($sformatf("up%0d count", k), int'(count), k % 16);
            check($sformatf("up%0d wrap", k), int'(wrap), (k == 16) ? 1 : 0);
            check($sformatf("up%0d tc", k), int'(tc), ((k % 16) == 15) ? 1 : 0);
        end

        //  rs en dir mode  mw mv  ld lv  st | cnt tc wr bsy dn
        // mod_wr below count clears it; then down-wrap around M=5
        add(1, 1, 1, 2'b00, 1, 5,  0, 0,   0,  0, 1, 0, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  5, 0, 1, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  4, 0, 0, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  3, 0, 0, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  2, 0, 0, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  1, 0, 0, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  0, 1, 0, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0,  0, 0,   0,  5, 0, 1, 0, 0);
        // saturate: load clamps to M, hold at M, then count down
        add(1, 0, 0, 2'b01, 1, 15, 0, 0,   0,  5, 0, 0, 0, 0);
        add(1, 0, 0, 2'b01, 0, 0,  1, 200, 0, 15, 1, 0, 0, 0);
        add(1, 1, 0, 2'b01, 0, 0,  0, 0,   0, 15, 1, 0, 0, 0);
        add(1, 1, 0, 2'b01, 0, 0,  0, 0,   0, 15, 1, 0, 0, 0);
        add(1, 1, 1, 2'b01, 0, 0,  0, 0,   0, 14, 0, 0, 0, 0);
        add(1, 1, 1, 2'b01, 0, 0,  0, 0,   0, 13, 0, 0, 0, 0);
        // one-shot with M=3, start ignored while running, restart from DONE
        add(1, 0, 0, 2'b10, 1, 3,  0, 0,   0,  0, 0, 0, 0, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   1,  0, 0, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  1, 0, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   1,  2, 0, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  3, 1, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  3, 1, 0, 0, 1);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  3, 1, 0, 0, 1);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   1,  0, 0, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  1, 0, 0, 1, 0);
        // simultaneous mod_wr/load/start: only M changes; then reset mid one-shot
        add(1, 1, 0, 2'b10, 1, 7,  1, 2,   1,  1, 0, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  2, 0, 0, 1, 0);
        add(0, 1, 0, 2'b10, 1, 3,  1, 9,   1,  0, 0, 0, 0, 0);
        add(1, 0, 0, 2'b00, 0, 0,  1, 200, 0, 15, 1, 0, 0, 0);
        // M=0: every enabled wrap-mode step wraps
        add(1, 1, 0, 2'b00, 1, 0,  0, 0,   0,  0, 1, 0, 0, 0);
        add(1, 1, 0, 2'b00, 0, 0,  0, 0,   0,  0, 1, 1, 0, 0);
        add(1, 1, 0, 2'b00, 0, 0,  0, 0,   0,  0, 1, 1, 0, 0);
        add(1, 1, 0, 2'b00, 0, 0,  0, 0,   0,  0, 1, 1, 0, 0);
        add(1, 1, 0, 2'b00, 0, 0,  0, 0,   0,  0, 1, 1, 0, 0);
        add(1, 0, 0, 2'b00, 0, 0,  0, 0,   0,  0, 1, 0, 0, 0);
        // M=0 one-shot finishes on first step; mode 11 behaves as wrap
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   1,  0, 1, 0, 1, 0);
        add(1, 1, 0, 2'b10, 0, 0,  0, 0,   0,  0, 1, 0, 0, 1);
        add(1, 1, 0, 2'b11, 0, 0,  0, 0,   0,  0, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            set_in(vecs[i].rstn, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].mw,
                   vecs[i].mv, vecs[i].ld, vecs[i].lv, vecs[i].st);
            tick();
            check($sformatf("row%0d count", i), int'(count), vecs[i].e_count);
            check($sformatf("row%0d tc", i), int'(tc), int'(vecs[i].e_tc));
            check($sformatf("row%0d wrap", i), int'(wrap), int'(vecs[i].e_wrap));
            check($sformatf("row%0d busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("row%0d done", i), int'(done), int'(vecs[i].e_done));
        end

        // Randomized traffic against the reference model
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 0, 1'b0);
        tick();
        for (int n = 0; n < 3000; n++) begin
            int mv;
            mv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 12));
            set_in(($urandom_range(0, 63) != 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0) ? ~dir : dir,
                   ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : mode,
                   ($urandom_range(0, 15) == 0), mv,
                   ($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)),
                   ($urandom_range(0, 7) == 0));
            tick();
            check($sformatf("rnd%0d count", n), int'(count), m_cnt);
            check($sformatf("rnd%0d tc", n), int'(tc),
                  ((dir == 1'b0 && m_cnt == m_mod) || (dir == 1'b1 && m_cnt == 0)) ? 1 : 0);
            check($sformatf("rnd%0d wrap", n), int'(wrap), m_wrap);
            check($sformatf("rnd%0d busy", n), int'(busy), (m_ph == 1) ? 1 : 0);
            check($sformatf("rnd%0d done", n), int'(done), (m_ph == 2) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
